// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: round-robin frame arbiter that merges two FWFT capture
// FIFOs onto one AXI4-Stream master. A frame of FrameSize words is granted only
// when the chosen FIFO already holds a full frame; tuser carries the channel ID.
module axis_frame_arbiter #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FrameSize            = 8,
  parameter int COUNT_WIDTH          = 10
) (
  input  logic                              m_axis_aclk,
  input  logic                              m_axis_aresetn,
  input  logic                              enable,
  input  logic                              fifo0_empty,
  input  logic [COUNT_WIDTH-1:0]            fifo0_count,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   fifo0_read_data,
  output logic                              fifo0_read_en,
  input  logic                              fifo1_empty,
  input  logic [COUNT_WIDTH-1:0]            fifo1_count,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   fifo1_read_data,
  output logic                              fifo1_read_en,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic [15:0]                       frame_count0,
  output logic [15:0]                       frame_count1,
  output logic                              busy,
  output logic                              underrun
);

  localparam int          STRB_W     = C_M_AXIS_TDATA_WIDTH / 8;
  localparam logic [31:0] FRAME_LEN32 = 32'(FrameSize);
  localparam logic [7:0]  FRAME_LEN   = 8'(FrameSize);
  localparam logic [7:0]  FRAME_LAST  = 8'(FrameSize - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Reset synchronizer: assertion is immediate, release is aligned to the clock.
  logic [1:0] rst_sync_r;
  logic       rst_int_n;

  // Two-flop reset release synchronizer.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_r[1];

  state_t                            state_r, state_s;
  logic                              grant_r, grant_s;
  logic                              rr_r, rr_s;
  logic [7:0]                        words_r, words_s;
  logic                              tvalid_r, tvalid_s;
  logic                              tlast_r, tlast_s;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata_r, tdata_s;
  logic [STRB_W-1:0]                 tstrb_r, tstrb_s;
  logic                              underrun_r, underrun_s;
  logic [15:0]                       fc0_r, fc0_s;
  logic [15:0]                       fc1_r, fc1_s;

  logic                              elig0_s, elig1_s;
  logic                              granted_empty_s;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   granted_data_s;
  logic                              load_s;

  // A channel may be granted only once it holds a whole frame.
  assign elig0_s = (32'(fifo0_count) >= FRAME_LEN32);
  assign elig1_s = (32'(fifo1_count) >= FRAME_LEN32);

  assign granted_empty_s = grant_r ? fifo1_empty : fifo0_empty;
  assign granted_data_s  = grant_r ? fifo1_read_data : fifo0_read_data;

  // Pop only when the output slot is free, words remain and the source has data.
  assign load_s = (state_r == SEND) && (!tvalid_r || m_axis_tready) &&
                  (words_r < FRAME_LEN) && !granted_empty_s;

  assign fifo0_read_en = load_s && (grant_r == 1'b0);
  assign fifo1_read_en = load_s && (grant_r == 1'b1);

  // Next-state and datapath decisions for the IDLE/SEND frame machine.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    rr_s       = rr_r;
    words_s    = words_r;
    tvalid_s   = tvalid_r;
    tlast_s    = tlast_r;
    tdata_s    = tdata_r;
    tstrb_s    = tstrb_r;
    underrun_s = underrun_r;
    fc0_s      = fc0_r;
    fc1_s      = fc1_r;

    case (state_r)
      IDLE: begin
        if (enable && (elig0_s || elig1_s)) begin
          state_s = SEND;
          if (rr_r == 1'b0) begin
            grant_s = elig0_s ? 1'b0 : 1'b1;
          end else begin
            grant_s = elig1_s ? 1'b1 : 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (load_s) begin
          tdata_s  = granted_data_s;
          tvalid_s = 1'b1;
          tstrb_s  = {STRB_W{1'b1}};
          words_s  = words_r + 8'd1;
          tlast_s  = (words_r == FRAME_LAST);
        end else if (tvalid_r && m_axis_tready) begin
          tvalid_s = 1'b0;
          if (tlast_r) begin
            tlast_s = 1'b0;
            words_s = 8'd0;
            rr_s    = ~grant_r;
            state_s = IDLE;
            if (grant_r) begin
              fc1_s = fc1_r + 16'd1;
            end else begin
              fc0_s = fc0_r + 16'd1;
            end
          end else begin
            tlast_s = tlast_r;
          end
        end else begin
          tvalid_s = tvalid_r;
        end
        // A source that runs dry before its frame is complete is flagged for the PS.
        if (granted_empty_s && (words_r < FRAME_LEN)) begin
          underrun_s = 1'b1;
        end else begin
          underrun_s = underrun_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by the internal reset.
  always_ff @(posedge m_axis_aclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_r    <= IDLE;
      grant_r    <= 1'b0;
      rr_r       <= 1'b0;
      words_r    <= 8'd0;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      tdata_r    <= '0;
      tstrb_r    <= '0;
      underrun_r <= 1'b0;
      fc0_r      <= 16'd0;
      fc1_r      <= 16'd0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      rr_r       <= rr_s;
      words_r    <= words_s;
      tvalid_r   <= tvalid_s;
      tlast_r    <= tlast_s;
      tdata_r    <= tdata_s;
      tstrb_r    <= tstrb_s;
      underrun_r <= underrun_s;
      fc0_r      <= fc0_s;
      fc1_r      <= fc1_s;
    end
  end

  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tstrb  = tstrb_r;
  assign m_axis_tlast  = tlast_r;
  assign m_axis_tuser  = grant_r;
  assign frame_count0  = fc0_r;
  assign frame_count1  = fc1_r;
  assign busy          = (state_r == SEND);
  assign underrun      = underrun_r;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: FIFO models feed the DUT, a
// frame-level reference model predicts beats, and a monitor checks them.
module tb_axis_frame_arbiter;

  localparam int DW = 32;
  localparam int FS = 8;
  localparam int CW = 10;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
    logic        first;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          fifo0_empty, fifo1_empty;
  logic [CW-1:0] fifo0_count, fifo1_count;
  logic [DW-1:0] fifo0_read_data, fifo1_read_data;
  logic          fifo0_read_en, fifo1_read_en;
  logic          tready, tvalid, tlast, tuser, busy, underrun;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic [15:0]   fc0, fc1;

  axis_frame_arbiter #(.C_M_AXIS_TDATA_WIDTH(DW), .FrameSize(FS), .COUNT_WIDTH(CW)) dut (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable),
    .fifo0_empty(fifo0_empty), .fifo0_count(fifo0_count),
    .fifo0_read_data(fifo0_read_data), .fifo0_read_en(fifo0_read_en),
    .fifo1_empty(fifo1_empty), .fifo1_count(fifo1_count),
    .fifo1_read_data(fifo1_read_data), .fifo1_read_en(fifo1_read_en),
    .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .m_axis_tstrb(tstrb), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .frame_count0(fc0), .frame_count1(fc1), .busy(busy), .underrun(underrun)
  );

  logic [31:0] q0[$], q1[$];     // live FIFO contents seen by the DUT
  logic [31:0] mq0[$], mq1[$];   // reference model copies
  beat_t       exp_q[$];
  int          mrr, exp_fc0, exp_fc1;
  int          errors, checks, cyc, beats, pops0, pops1, prev_cyc, tmode;
  bit          force0, p0, p1, gap_en, have_prev;
  bit          stall_prev;
  logic [31:0] s_data;
  logic        s_last, s_user;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo0_empty     = force0 || (q0.size() == 0);
    fifo1_empty     = (q1.size() == 0);
    fifo0_count     = CW'(q0.size());
    fifo1_count     = CW'(q1.size());
    fifo0_read_data = (q0.size() != 0) ? q0[0] : 32'h0;
    fifo1_read_data = (q1.size() != 0) ? q1[0] : 32'h0;
  endtask

  task automatic push0(input logic [31:0] d);
    q0.push_back(d);
    mq0.push_back(d);
  endtask

  task automatic push1(input logic [31:0] d);
    q1.push_back(d);
    mq1.push_back(d);
  endtask

  // Reference model: grant whole frames round-robin while any channel holds FS words.
  task automatic model_grants();
    beat_t b;
    bit    e0, e1;
    int    ch;
    forever begin
      e0 = (mq0.size() >= FS);
      e1 = (mq1.size() >= FS);
      if (!e0 && !e1) break;
      if (mrr == 0) ch = e0 ? 0 : 1;
      else          ch = e1 ? 1 : 0;
      for (int i = 0; i < FS; i++) begin
        b.data  = (ch == 1) ? mq1.pop_front() : mq0.pop_front();
        b.user  = (ch == 1);
        b.last  = (i == FS - 1);
        b.first = (i == 0);
        exp_q.push_back(b);
      end
      mrr = 1 - ch;
      if (ch == 1) exp_fc1++;
      else         exp_fc0++;
    end
  endtask

  // FIFO driver: apply pops decided in the previous cycle, then present new state.
  initial begin
    force0 = 1'b0;
    p0 = 1'b0;
    p1 = 1'b0;
    tmode = 0;
    tready = 1'b1;
    refresh();
    forever begin
      @(posedge clk);
      #2;
      if (p0) begin
        if (q0.size() != 0) void'(q0.pop_front());
        pops0++;
      end
      if (p1) begin
        if (q1.size() != 0) void'(q1.pop_front());
        pops1++;
      end
      refresh();
      case (tmode)
        1:       tready = ((cyc % 3) == 0);
        2:       tready = ($urandom_range(0, 3) != 0);
        default: tready = 1'b1;
      endcase
    end
  end

  // Monitor: score accepted beats, AXIS hold rules and pop legality.
  initial begin
    beat_t b;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      p0 = fifo0_read_en;
      p1 = fifo1_read_en;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (fifo0_read_en || fifo1_read_en)
          chk("single_pop", 32'(fifo0_read_en & fifo1_read_en), 32'd0);
        if (fifo0_read_en) chk("pop0_nonempty", 32'(fifo0_empty), 32'd0);
        if (fifo1_read_en) chk("pop1_nonempty", 32'(fifo1_empty), 32'd0);
        if (tvalid && !tready)
          chk("no_pop_in_stall", 32'(fifo0_read_en | fifo1_read_en), 32'd0);
        if (stall_prev) begin
          chk("hold_tvalid", 32'(tvalid), 32'd1);
          chk("hold_tdata", tdata, s_data);
          chk("hold_tlast", 32'(tlast), 32'(s_last));
          chk("hold_tuser", 32'(tuser), 32'(s_user));
        end
        stall_prev = tvalid && !tready;
        s_data = tdata;
        s_last = tlast;
        s_user = tuser;
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", tdata, 32'hDEAD_BEEF);
          end else begin
            b = exp_q.pop_front();
            chk("tdata", tdata, b.data);
            chk("tuser", 32'(tuser), 32'(b.user));
            chk("tlast", 32'(tlast), 32'(b.last));
            chk("tstrb", 32'(tstrb), 32'hF);
            if (gap_en) begin
              if (!b.first)      chk("beat_gap", 32'(cyc - prev_cyc), 32'd1);
              else if (have_prev) chk("frame_gap", 32'(cyc - prev_cyc), 32'd3);
            end
            have_prev = 1'b1;
            prev_cyc = cyc;
          end
          beats++;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int base;
    base = beats;
    for (int i = 0; i < budget && beats < base + n; i++) @(negedge clk);
    chk("beats_reached", 32'(beats >= base + n), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); mq0.delete(); mq1.delete(); exp_q.delete();
    mrr = 0; exp_fc0 = 0; exp_fc1 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    errors = 0; checks = 0; beats = 0; pops0 = 0; pops1 = 0;
    gap_en = 1'b0; have_prev = 1'b0; prev_cyc = 0;
    mrr = 0; exp_fc0 = 0; exp_fc1 = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_tuser", 32'(tuser), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tstrb", 32'(tstrb), 32'd0);
    chk("rst_fc0", 32'(fc0), 32'd0);
    chk("rst_fc1", 32'(fc1), 32'd0);
    chk("rst_rd_en", 32'(fifo0_read_en | fifo1_read_en), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b1;

    // Single frame from channel 0 with grant latency and back-to-back beats.
    have_prev = 1'b0; gap_en = 1'b1;
    n0 = pops0;
    for (int i = 0; i < FS; i++) push0(32'h100 + 32'(i));
    model_grants();
    @(negedge clk);
    chk("lat_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("lat_send_busy", 32'(busy), 32'd1);
    chk("lat_send_tvalid", 32'(tvalid), 32'd0);
    @(negedge clk);
    chk("lat_first_tvalid", 32'(tvalid), 32'd1);
    wait_drain(100);
    chk("single_fc0", 32'(fc0), 32'(exp_fc0));
    chk("single_pops0", 32'(pops0 - n0), 32'(FS));

    // Round-robin with both channels full from reset.
    do_reset();
    have_prev = 1'b0; gap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push0(32'h200 + 32'(i));
      push1(32'h300 + 32'(i));
    end
    model_grants();
    wait_drain(300);
    gap_en = 1'b0;
    chk("rr_fc0", 32'(fc0), 32'd2);
    chk("rr_fc1", 32'(fc1), 32'd2);

    // Backpressure on channel 1.
    tmode = 1;
    for (int i = 0; i < FS; i++) push1($urandom);
    model_grants();
    wait_drain(300);
    tmode = 0;
    chk("bp_fc1", 32'(fc1), 32'(exp_fc1));

    // Threshold and enable gating.
    @(posedge clk); #1;
    for (int i = 0; i < FS - 1; i++) push0(32'h400 + 32'(i));
    repeat (5) @(negedge clk);
    chk("thr_busy", 32'(busy), 32'd0);
    chk("thr_tvalid", 32'(tvalid), 32'd0);
    @(posedge clk); #1;
    enable = 1'b0;
    push0(32'h400 + 32'(FS - 1));
    repeat (5) @(negedge clk);
    chk("en_off_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    model_grants();
    @(negedge clk);
    chk("en_on_busy_pre", 32'(busy), 32'd0);
    @(negedge clk);
    chk("en_on_busy", 32'(busy), 32'd1);
    wait_beats(3, 50);
    @(posedge clk); #1;
    enable = 1'b0;
    wait_drain(100);
    chk("en_drop_fc0", 32'(fc0), 32'(exp_fc0));
    repeat (4) @(negedge clk);
    chk("en_drop_idle", 32'(busy), 32'd0);

    // Underrun: source runs dry mid-frame, then recovers.
    chk("ur_clear", 32'(underrun), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < FS; i++) push0(32'h500 + 32'(i));
    model_grants();
    wait_beats(4, 50);
    @(posedge clk); #1;
    force0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_tvalid_low", 32'(tvalid), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    force0 = 1'b0;
    wait_drain(100);
    chk("ur_sticky", 32'(underrun), 32'd1);
    chk("ur_fc0", 32'(fc0), 32'(exp_fc0));

    // Reset in the middle of a frame.
    for (int i = 0; i < FS; i++) push0(32'h580 + 32'(i));
    model_grants();
    wait_beats(3, 50);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
    chk("mid_rst_tlast", 32'(tlast), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    chk("mid_rst_tdata", tdata, 32'd0);
    chk("mid_rst_fc0", 32'(fc0), 32'd0);
    q0.delete(); q1.delete(); mq0.delete(); mq1.delete(); exp_q.delete();
    mrr = 0; exp_fc0 = 0; exp_fc1 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < FS; i++) push0(32'h600 + 32'(i));
    model_grants();
    wait_drain(100);
    chk("post_rst_fc0", 32'(fc0), 32'd1);

    // Randomized fills with random backpressure.
    tmode = 2;
    for (int it = 0; it < 4; it++) begin
      @(posedge clk); #1;
      n0 = int'($urandom_range(0, 30));
      n1 = int'($urandom_range(0, 30));
      for (int i = 0; i < n0; i++) push0($urandom);
      for (int i = 0; i < n1; i++) push1($urandom);
      model_grants();
      wait_drain(2000);
      chk("rand_fc0", 32'(fc0), 32'(exp_fc0));
      chk("rand_fc1", 32'(fc1), 32'(exp_fc1));
    end
    tmode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
